// File: rtl/ring_osc_pkg.sv
// Shared types and default sizing for the ring oscillator measurement controller.
package ring_osc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } meas_state_t;

    localparam int RO_SETTLE_CYCLES = 4;
    localparam int RO_GATE_CYCLES   = 256;
    localparam int RO_CNT_W         = 12;

endpackage

// File: rtl/ring_osc_meas_ctrl_edge_sync.sv
// Two-flop synchronizer for the free-running oscillator plus a third flop for rising-edge detect.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // All three flops clear together so no spurious edge is reported after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Sequences one ring-oscillator frequency measurement: enable, settle, count edges over a gate window, report.
module ring_osc_meas_ctrl
    import ring_osc_pkg::*;
#(
    parameter int SETTLE_CYCLES = RO_SETTLE_CYCLES,
    parameter int GATE_CYCLES   = RO_GATE_CYCLES,
    parameter int CNT_W         = RO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             osc_in,
    output logic             ring_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX     = '1;

    meas_state_t      state_q,   state_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [CNT_W-1:0] acc_q,     acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             ovf_q,     ovf_d;
    logic             ring_en_q, ring_en_d;
    logic             done_q,    done_d;
    logic             rise;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (osc_in),
        .rise     (rise)
    );

    // Handshake: start is a request sampled only in IDLE (no queueing while busy);
    // done is a single-cycle strobe and count/ovf are valid from that cycle until the next done.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                acc_d     = '0;
                ovf_acc_d = 1'b0;
                if (start && !abort) begin
                    state_d = SETTLE;
                    timer_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = GATE;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GATE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (rise) begin
                        if (acc_q == ACC_MAX) ovf_acc_d = 1'b1;
                        else                  acc_d     = acc_q + 1'b1;
                    end
                    // Publish on the way into DONE so the result lines up with the done strobe.
                    if (timer_q == '0) begin
                        state_d = DONE;
                        count_d = acc_d;
                        ovf_d   = ovf_acc_d;
                        done_d  = 1'b1;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ring_en_d = (state_d == SETTLE) || (state_d == GATE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ring_en_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            ring_en_q <= ring_en_d;
            done_q    <= done_d;
        end
    end

    assign ring_en   = ring_en_q;
    assign busy      = ring_en_q;
    assign done      = done_q;
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Bench for ring_osc_meas_ctrl: a default-sized instance and a narrow-counter instance share clk, rst and osc_in.
module tb_ring_osc_meas_ctrl;

    localparam int S  = 4;
    localparam int G  = 256;
    localparam int W  = 12;
    localparam int WS = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_n = 1'b0, abort_n = 1'b0;
    logic start_s = 1'b0, abort_s = 1'b0;
    logic osc_in  = 1'b0;

    logic          ring_en_n, busy_n, done_n, ovf_n;
    logic [W-1:0]  count_n;
    logic [1:0]    state_n;
    logic          ring_en_s, busy_s, done_s, ovf_s;
    logic [WS-1:0] count_s;
    logic [1:0]    state_s;

    ring_osc_meas_ctrl dut (
        .clk (clk), .rst (rst), .start (start_n), .abort (abort_n), .osc_in (osc_in),
        .ring_en (ring_en_n), .busy (busy_n), .done (done_n), .count (count_n), .ovf (ovf_n),
        .dbg_state (state_n)
    );

    ring_osc_meas_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(WS)) dut_sat (
        .clk (clk), .rst (rst), .start (start_s), .abort (abort_s), .osc_in (osc_in),
        .ring_en (ring_en_s), .busy (busy_s), .done (done_s), .count (count_s), .ovf (ovf_s),
        .dbg_state (state_s)
    );

    // Selected instance view
    logic         sel = 1'b0;
    logic         m_ring_en, m_busy, m_done, m_ovf;
    logic [W-1:0] m_count;
    logic [1:0]   m_state;
    assign m_ring_en = sel ? ring_en_s : ring_en_n;
    assign m_busy    = sel ? busy_s    : busy_n;
    assign m_done    = sel ? done_s    : done_n;
    assign m_ovf     = sel ? ovf_s     : ovf_n;
    assign m_count   = sel ? {{(W-WS){1'b0}}, count_s} : count_n;
    assign m_state   = sel ? state_s   : state_n;

    // Reference model input: osc_in as seen at every rising clock edge, indexed by edge number
    int   cyc = 0;
    logic osc_log [0:65535];
    always @(posedge clk) begin
        cyc = cyc + 1;
        osc_log[cyc] = osc_in;
    end

    int vectors    = 0;
    int miscompares = 0;
    int half_left  = 0;
    int hold_cnt   [2];
    int hold_ovf   [2];
    bit hold_known [2];

    // ---------------- driver tasks ----------------
    task automatic set_start(input logic v);
        if (sel) start_s = v; else start_n = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) abort_s = v; else abort_n = v;
    endtask

    // mode 0: stuck low, 1: toggle every 2 clk, 2: toggle every clk, 3: random half period 2..6 clk
    task automatic drive_osc(input int mode);
        if (mode == 0) begin
            osc_in = 1'b0;
        end else if (half_left <= 1) begin
            osc_in = ~osc_in;
            half_left = (mode == 1) ? 2 : (mode == 2) ? 1 : int'($urandom_range(6, 2));
        end else begin
            half_left = half_left - 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising transitions of the sampled oscillator over edges lo..hi
    function automatic int model_rises(input int lo, input int hi);
        int r = 0;
        for (int j = lo; j <= hi; j++)
            if (osc_log[j-1] === 1'b0 && osc_log[j] === 1'b1) r++;
        return r;
    endfunction

    // One measurement on the selected instance; entered and left on a negedge in IDLE.
    task automatic do_meas(input int mode, input int abort_at, input bit repulse);
        int k, e, done_at, raw, cmax, exp_c, exp_o, diff;
        bit aborted, exp_en, exp_done, exact;
        cmax  = sel ? (1 << WS) - 1 : (1 << W) - 1;
        exact = (mode != 3);
        half_left = 0;
        set_start(1'b1);
        k = cyc + 1;
        done_at = k + S + G;
        for (int n = 0; n < S + G + 2; n++) begin
            @(negedge clk);
            e = cyc;
            set_start(1'b0);
            set_abort(1'b0);
            if (repulse && (e == k + 2 || e == k + S + 10)) set_start(1'b1);
            if (abort_at >= 0 && e == k + S + abort_at) set_abort(1'b1);
            drive_osc(mode);
            aborted  = (abort_at >= 0) && (e > k + S + abort_at);
            exp_en   = !aborted && e >= k && e < done_at;
            exp_done = !aborted && e == done_at;
            vectors++;
            if (m_ring_en !== exp_en || m_busy !== exp_en) begin
                miscompares++;
                $display("FAIL enable@%0d: ring_en=%b busy=%b expected %b", e - k, m_ring_en, m_busy, exp_en);
            end
            vectors++;
            if (m_done !== exp_done) begin
                miscompares++;
                $display("FAIL done@%0d: got %b expected %b", e - k, m_done, exp_done);
            end
            if (exp_done) begin
                raw   = model_rises(k + S, k + S + G - 1);
                exp_c = (raw > cmax) ? cmax : raw;
                exp_o = (raw > cmax) ? 1 : 0;
                diff  = int'(m_count) - exp_c;
                vectors++;
                if (exact ? (diff != 0) : (diff > 1 || diff < -1)) begin
                    miscompares++;
                    $display("FAIL count mode%0d: got %0d expected %0d (tol %0d)", mode, m_count, exp_c, exact ? 0 : 1);
                end
                if (exact || raw >= cmax + 2 || raw <= cmax - 1) begin
                    vectors++;
                    if (m_ovf !== exp_o[0]) begin
                        miscompares++;
                        $display("FAIL ovf mode%0d: got %b expected %0d", mode, m_ovf, exp_o);
                    end
                end
                hold_known[sel] = exact;
                hold_cnt[sel]   = exp_c;
                hold_ovf[sel]   = exp_o;
            end else if (hold_known[sel]) begin
                vectors++;
                if (int'(m_count) != hold_cnt[sel] || m_ovf !== hold_ovf[sel][0]) begin
                    miscompares++;
                    $display("FAIL hold@%0d: count=%0d ovf=%b expected %0d/%0d", e - k, m_count, m_ovf, hold_cnt[sel], hold_ovf[sel]);
                end
            end
            if (aborted && e >= k + S + abort_at + 4) break;
        end
        set_abort(1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        vectors++;
        if ({ring_en_n, busy_n, done_n, ovf_n, state_n} !== 6'b0 || count_n !== '0) begin
            miscompares++;
            $display("FAIL reset_main: en=%b busy=%b done=%b count=%0d ovf=%b", ring_en_n, busy_n, done_n, count_n, ovf_n);
        end
        vectors++;
        if ({ring_en_s, busy_s, done_s, ovf_s, state_s} !== 6'b0 || count_s !== '0) begin
            miscompares++;
            $display("FAIL reset_sat: en=%b busy=%b done=%b count=%0d ovf=%b", ring_en_s, busy_s, done_s, count_s, ovf_s);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hold_known[i] = 1'b1; hold_cnt[i] = 0; hold_ovf[i] = 0;
        end
        idle(1);
    endtask

    task automatic test_nominal;
        sel = 1'b0;
        idle(8);
        do_meas(1, -1, 1'b0);
    endtask

    task automatic test_abort;
        idle(3);
        do_meas(1, 100, 1'b0);
    endtask

    task automatic test_stuck;
        idle(2);
        do_meas(0, -1, 1'b0);
    endtask

    task automatic test_saturation;
        sel = 1'b1;
        idle(2);
        do_meas(2, -1, 1'b0);
        do_meas(0, -1, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_protocol;
        idle(2);
        do_meas(3, -1, 1'b1);
        set_start(1'b1);
        set_abort(1'b1);
        @(negedge clk);
        set_start(1'b0);
        set_abort(1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (m_ring_en !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_state !== 2'd0) begin
                miscompares++;
                $display("FAIL start_abort_idle: en=%b busy=%b done=%b state=%0d", m_ring_en, m_busy, m_done, m_state);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        idle(1);
        do_meas(1, -1, 1'b0);
        do_meas(1, -1, 1'b0);
        do_meas(3, -1, 1'b0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            idle($urandom_range(5, 1));
            if ($urandom_range(1, 0) == 1) do_meas(3, $urandom_range(G - 1, 0), 1'b0);
            else                           do_meas(3, -1, 1'b0);
        end
        do_meas(1, -1, 1'b0);
    endtask

    task automatic test_async_reset;
        sel = 1'b0;
        half_left = 0;
        idle(2);
        set_start(1'b1);
        repeat (S + 60) begin
            @(negedge clk);
            set_start(1'b0);
            drive_osc(1);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({ring_en_n, busy_n, done_n, ovf_n, state_n} !== 6'b0 || count_n !== '0) begin
            miscompares++;
            $display("FAIL async_reset: en=%b busy=%b done=%b count=%0d ovf=%b state=%0d", ring_en_n, busy_n, done_n, count_n, ovf_n, state_n);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hold_known[i] = 1'b1; hold_cnt[i] = 0; hold_ovf[i] = 0;
        end
        idle(2);
        do_meas(1, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_abort();
        test_stuck();
        test_saturation();
        test_protocol();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
